// File: rtl/spi_reg_write_ctrl_pkg.sv
// Shared definitions for the SPI command sequencer and its register-file clients.
// Holds the FSM encoding, address-byte field positions and default sizing.
package tone_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DROP = 2'd3
    } state_e;

    localparam int AI_BIT       = 7;
    localparam int DEF_ADDR_W   = 4;
    localparam int DEF_NUM_REGS = 16;

    // True when no address-byte bit between bit 6 and the address field is set.
    function automatic logic addr_hi_clear(input logic [6:0] field, input int addr_w);
        return (field >> addr_w) == 7'd0;
    endfunction

endpackage

// File: rtl/spi_reg_write_ctrl_if.sv
// Register-write bus between the command sequencer (master) and a register file (slave).
// valid/ready: a write transfers on any clock where valid and ready are both high; while
// valid is high and not yet accepted, addr and data are held stable by the master.
interface spi_reg_write_ctrl_if #(
    parameter int ADDR_W = 4
);
    logic              reg_wr_valid_out;
    logic              reg_wr_ready_in;
    logic [ADDR_W-1:0] reg_addr_out;
    logic [7:0]        reg_data_out;

    modport master (
        output reg_wr_valid_out,
        output reg_addr_out,
        output reg_data_out,
        input  reg_wr_ready_in
    );

    modport slave (
        input  reg_wr_valid_out,
        input  reg_addr_out,
        input  reg_data_out,
        output reg_wr_ready_in
    );
endinterface

// File: rtl/spi_reg_write_ctrl_wr_hold_reg.sv
// One-entry valid/ready holding register for register-write requests.
// A load while a request is stalled is dropped and reported on the overrun strobe.
module wr_hold_reg #(
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [7:0]        data_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [7:0]        data_o,
    output logic              overrun_o
);

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic              stall;
    logic              take;

    // A completing transfer frees the slot in the same cycle, so back-to-back loads succeed.
    assign stall     = valid_q & ~ready_i;
    assign take      = load_i & ~stall;
    assign overrun_o = load_i & stall;

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (take) begin
            valid_d = 1'b1;
            addr_d  = addr_i;
            data_d  = data_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= 8'd0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign addr_o  = addr_q;
    assign data_o  = data_q;

endmodule

// File: rtl/spi_reg_write_ctrl.sv
// Splits each chip-select transaction into an address byte plus data bytes and issues
// one register write per data byte, with optional address auto-increment and sticky errors.
module spi_reg_write_ctrl
    import tone_gen_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_REGS = DEF_NUM_REGS
) (
    input  logic                        clk_in,
    input  logic                        reset_n_in,
    input  logic [7:0]                  rx_data_in,
    input  logic                        rx_valid_in,
    input  logic                        transaction_valid_in,
    spi_reg_write_ctrl_if.master        reg_wr,
    output logic                        busy_out,
    output logic                        addr_err_out,
    output logic                        overrun_out,
    input  logic                        err_clear_in,
    output logic [1:0]                  dbg_state_out
);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] ADDR = ST_ADDR;
    localparam logic [1:0] DATA = ST_DATA;
    localparam logic [1:0] DROP = ST_DROP;

    localparam logic [7:0]        NUM_REGS_B = 8'(NUM_REGS);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_REGS - 1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ai_q, ai_d;
    logic              addr_err_q, addr_err_d;
    logic              overrun_q, overrun_d;

    logic              load;
    logic              addr_err_set;
    logic              overrun_set;
    logic              addr_legal;
    logic [7:0]        addr_field;
    logic [ADDR_W-1:0] addr_next;

    assign addr_field = 8'(rx_data_in[ADDR_W-1:0]);
    assign addr_legal = addr_hi_clear(rx_data_in[6:0], ADDR_W) && (addr_field < NUM_REGS_B);
    assign addr_next  = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);

    // Chip-select loss wins over a coincident byte in every active state.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        ai_d         = ai_q;
        load         = 1'b0;
        addr_err_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (transaction_valid_in) state_d = ADDR;
            end
            ADDR: begin
                if (!transaction_valid_in) begin
                    state_d = IDLE;
                end else if (rx_valid_in) begin
                    if (addr_legal) begin
                        addr_d  = rx_data_in[ADDR_W-1:0];
                        ai_d    = rx_data_in[AI_BIT];
                        state_d = DATA;
                    end else begin
                        addr_err_set = 1'b1;
                        state_d      = DROP;
                    end
                end
            end
            DATA: begin
                if (!transaction_valid_in) begin
                    state_d = IDLE;
                end else if (rx_valid_in) begin
                    load = 1'b1;
                    // Advance even when the byte is dropped so later bytes keep their position.
                    if (ai_q) addr_d = addr_next;
                end
            end
            DROP: begin
                if (!transaction_valid_in) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    wr_hold_reg #(
        .ADDR_W (ADDR_W)
    ) u_hold (
        .clk_i     (clk_in),
        .rst_ni    (reset_n_in),
        .load_i    (load),
        .addr_i    (addr_q),
        .data_i    (rx_data_in),
        .ready_i   (reg_wr.reg_wr_ready_in),
        .valid_o   (reg_wr.reg_wr_valid_out),
        .addr_o    (reg_wr.reg_addr_out),
        .data_o    (reg_wr.reg_data_out),
        .overrun_o (overrun_set)
    );

    // A new error in the same cycle as a clear must survive.
    assign addr_err_d = addr_err_set | (addr_err_q & ~err_clear_in);
    assign overrun_d  = overrun_set  | (overrun_q  & ~err_clear_in);

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            ai_q       <= 1'b0;
            addr_err_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            ai_q       <= ai_d;
            addr_err_q <= addr_err_d;
            overrun_q  <= overrun_d;
        end
    end

    assign busy_out      = (state_q != IDLE);
    assign addr_err_out  = addr_err_q;
    assign overrun_out   = overrun_q;
    assign dbg_state_out = state_q;

endmodule

// File: tb/tb_spi_reg_write_ctrl.sv
// Directed bench for spi_reg_write_ctrl: a 16-register instance for the main flows and a
// 12-register instance for the out-of-range address case.
module tb_spi_reg_write_ctrl;
    import tone_gen_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       cs;
    logic       cs12;
    logic       err_clr;
    logic       ready;

    spi_reg_write_ctrl_if #(.ADDR_W(4)) bus16 ();
    spi_reg_write_ctrl_if #(.ADDR_W(4)) bus12 ();
    assign bus16.reg_wr_ready_in = ready;
    assign bus12.reg_wr_ready_in = ready;

    logic       busy16, aerr16, ovr16;
    logic       busy12, aerr12, ovr12;
    logic [1:0] st16, st12;

    spi_reg_write_ctrl #(.ADDR_W(4), .NUM_REGS(16)) dut16 (
        .clk_in               (clk),
        .reset_n_in           (rst_n),
        .rx_data_in           (rx_data),
        .rx_valid_in          (rx_valid),
        .transaction_valid_in (cs),
        .reg_wr               (bus16),
        .busy_out             (busy16),
        .addr_err_out         (aerr16),
        .overrun_out          (ovr16),
        .err_clear_in         (err_clr),
        .dbg_state_out        (st16)
    );

    spi_reg_write_ctrl #(.ADDR_W(4), .NUM_REGS(12)) dut12 (
        .clk_in               (clk),
        .reset_n_in           (rst_n),
        .rx_data_in           (rx_data),
        .rx_valid_in          (rx_valid),
        .transaction_valid_in (cs12),
        .reg_wr               (bus12),
        .busy_out             (busy12),
        .addr_err_out         (aerr12),
        .overrun_out          (ovr12),
        .err_clear_in         (err_clr),
        .dbg_state_out        (st12)
    );

    // ---------------- scoreboard ----------------
    int          n_vec   = 0;
    int          n_err   = 0;
    int          n_extra = 0;
    int          n_wr12  = 0;
    logic [11:0] exp_q[$];
    logic [11:0] exp_e;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // Transfers are judged just after the falling edge, once drivers have settled.
    always begin
        @(negedge clk);
        #1;
        if (bus16.reg_wr_valid_out && ready) begin
            if (exp_q.size() == 0) begin
                n_extra++;
            end else begin
                exp_e = exp_q.pop_front();
                check("wr16", 32'({bus16.reg_addr_out, bus16.reg_data_out}), 32'(exp_e));
            end
        end
        if (bus12.reg_wr_valid_out && ready) n_wr12++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic start_tx(input logic with12);
        @(negedge clk);
        cs   = 1'b1;
        cs12 = with12;
        @(negedge clk);
    endtask

    task automatic end_tx();
        @(negedge clk);
        cs   = 1'b0;
        cs12 = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        cs       = 1'b0;
        cs12     = 1'b0;
        err_clr  = 1'b0;
        ready    = 1'b1;

        tick(3);
        check("rst_valid", 32'(bus16.reg_wr_valid_out), 0);
        check("rst_addr",  32'(bus16.reg_addr_out), 0);
        check("rst_data",  32'(bus16.reg_data_out), 0);
        check("rst_busy",  32'(busy16), 0);
        check("rst_flags", 32'({aerr16, ovr16}), 0);
        rst_n = 1'b1;
        tick(1);
        check("post_rst_state", 32'(st16), 0);

        // Single write, ready held high.
        start_tx(1'b0);
        check("t1_busy", 32'(busy16), 1);
        send_byte(8'h03);
        exp_q.push_back({4'h3, 8'hA5});
        send_byte(8'hA5);
        check("t1_valid", 32'(bus16.reg_wr_valid_out), 1);
        check("t1_addr",  32'(bus16.reg_addr_out), 3);
        check("t1_data",  32'(bus16.reg_data_out), 32'hA5);
        tick(1);
        check("t1_pulse", 32'(bus16.reg_wr_valid_out), 0);
        end_tx();
        check("t1_idle",  32'(busy16), 0);
        check("t1_flags", 32'({aerr16, ovr16}), 0);
        check("t1_drain", 32'(exp_q.size()), 0);

        // Auto-increment wraps from the last register back to 0.
        start_tx(1'b0);
        exp_q.push_back({4'hE, 8'h11});
        exp_q.push_back({4'hF, 8'h22});
        exp_q.push_back({4'h0, 8'h33});
        send_byte(8'h8E);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        tick(2);
        end_tx();
        check("t2_drain", 32'(exp_q.size()), 0);

        // No auto-increment: every byte hits the same register.
        start_tx(1'b0);
        exp_q.push_back({4'h5, 8'h10});
        exp_q.push_back({4'h5, 8'h20});
        send_byte(8'h05);
        send_byte(8'h10);
        send_byte(8'h20);
        tick(2);
        end_tx();
        check("t3_drain", 32'(exp_q.size()), 0);

        // Address 0x0C is out of range for 12 registers but legal for 16.
        start_tx(1'b1);
        exp_q.push_back({4'hC, 8'h55});
        send_byte(8'h0C);
        check("t4_state12", 32'(st12), 2'd3);
        check("t4_aerr12",  32'(aerr12), 1);
        send_byte(8'h55);
        tick(1);
        check("t4_aerr16",  32'(aerr16), 0);
        end_tx();
        check("t4_nowr12",  32'(n_wr12), 0);
        check("t4_drain",   32'(exp_q.size()), 0);
        pulse_clear();
        check("t4_clr12",   32'(aerr12), 0);

        // Nonzero high address bits, with a clear in the same cycle as the error.
        start_tx(1'b0);
        err_clr = 1'b1;
        send_byte(8'h10);
        err_clr = 1'b0;
        check("t4b_set_wins", 32'(aerr16), 1);
        check("t4b_drop",     32'(st16), 2'd3);
        send_byte(8'h99);
        tick(1);
        end_tx();
        pulse_clear();
        check("t4b_clr", 32'(aerr16), 0);

        // Backpressure: second data byte is dropped but still advances the address.
        ready = 1'b0;
        start_tx(1'b0);
        send_byte(8'h82);
        send_byte(8'hAA);
        check("t5_valid", 32'(bus16.reg_wr_valid_out), 1);
        check("t5_addr",  32'(bus16.reg_addr_out), 2);
        check("t5_ovr0",  32'(ovr16), 0);
        send_byte(8'hBB);
        check("t5_ovr1",  32'(ovr16), 1);
        check("t5_held",  32'({bus16.reg_wr_valid_out, bus16.reg_addr_out, bus16.reg_data_out}),
              32'({1'b1, 4'h2, 8'hAA}));
        exp_q.push_back({4'h2, 8'hAA});
        tick(1);
        ready = 1'b1;
        tick(1);
        check("t5_done",  32'(bus16.reg_wr_valid_out), 0);
        exp_q.push_back({4'h4, 8'hCC});
        send_byte(8'hCC);
        check("t5_next_addr", 32'(bus16.reg_addr_out), 4);
        tick(1);
        end_tx();
        check("t5_drain", 32'(exp_q.size()), 0);
        pulse_clear();
        check("t5_clr",   32'(ovr16), 0);

        // Chip-select abort right after the address byte; next one parses a new address.
        start_tx(1'b0);
        send_byte(8'h07);
        end_tx();
        check("t6_busy",  32'(busy16), 0);
        check("t6_state", 32'(st16), 0);
        start_tx(1'b0);
        exp_q.push_back({4'h9, 8'h66});
        send_byte(8'h09);
        send_byte(8'h66);
        tick(1);
        check("t6_drain", 32'(exp_q.size()), 0);

        // Chip-select drop coincident with a byte: that byte is ignored.
        @(negedge clk);
        cs       = 1'b0;
        rx_data  = 8'h77;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        check("t6_cs_prio_busy",  32'(busy16), 0);
        check("t6_cs_prio_valid", 32'(bus16.reg_wr_valid_out), 0);
        tick(2);

        // Asynchronous reset while a stalled write is pending.
        ready = 1'b0;
        start_tx(1'b0);
        send_byte(8'h03);
        send_byte(8'h44);
        check("t7_pending", 32'(bus16.reg_wr_valid_out), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t7_rst_out", 32'({bus16.reg_wr_valid_out, bus16.reg_addr_out, bus16.reg_data_out}), 0);
        check("t7_rst_busy", 32'({busy16, st16}), 0);
        cs = 1'b0;
        @(negedge clk);
        ready = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        check("t7_no_wr", 32'(bus16.reg_wr_valid_out), 0);

        check("extra_writes", 32'(n_extra), 0);
        check("final_drain",  32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_reg_write_ctrl.md
Name: spi_reg_write_ctrl

Overview:
- Command sequencer between the SPI byte receiver and the tone-generator register file.
- Parses each chip-select transaction into one address byte followed by N data bytes.
- Issues one valid/ready register-write request per data byte, with optional address auto-increment.
- Flags malformed addresses and overruns with sticky error bits.

Parameters:
- ADDR_W, 4, register address width; must be 1..7.
- NUM_REGS, 16, number of implemented registers; legal addresses are 0..NUM_REGS-1; NUM_REGS <= 2^ADDR_W.

Ports:
- clk_in  input  1  system clock
- reset_n_in  input  1  asynchronous, active-low reset
- rx_data_in  input  8  received byte from the SPI receiver
- rx_valid_in  input  1  one-cycle strobe; rx_data_in is valid
- transaction_valid_in  input  1  high while chip select is active (synchronised)
- reg_wr_valid_out  output  1  write request pending
- reg_wr_ready_in  input  1  register file accepts the write this cycle
- reg_addr_out  output  ADDR_W  write address; stable while valid
- reg_data_out  output  8  write data; stable while valid
- busy_out  output  1  a transaction is in progress (state != IDLE)
- addr_err_out  output  1  sticky: illegal address byte received
- overrun_out  output  1  sticky: data byte dropped due to backpressure
- err_clear_in  input  1  synchronous clear of both sticky flags

Behaviour:
- Reset: asynchronous assert on reset_n_in low; synchronous release.
- Values held in reset: all outputs 0, state IDLE, internal address 0, auto-increment flag 0.
- Reset mid-transaction or with a write pending discards everything; no write request follows release.
- State machine:
  - IDLE: on transaction_valid_in=1 -> ADDR.
  - ADDR: on rx_valid_in, decode the address byte:
    - bit7 = auto-increment enable (AI).
    - bits[ADDR_W-1:0] = start address.
    - Illegal if any of bits[6:ADDR_W] != 0 or address >= NUM_REGS.
    - Legal -> latch address and AI, go to DATA.
    - Illegal -> set addr_err_out, go to DROP.
  - DATA: each rx_valid_in is one data byte (see Data bytes and Backpressure).
  - DROP: ignore all bytes.
  - From ADDR/DATA/DROP: transaction_valid_in=0 -> IDLE, same cycle, with priority over a coincident rx_valid_in (that byte is ignored).
- Data bytes:
  - Load the holding register {addr, byte}; reg_wr_valid_out rises the next cycle.
  - Latency: rx_valid_in in cycle T -> reg_wr_valid_out high in T+1.
  - AI=1: after each data byte the address increments; NUM_REGS-1 wraps to 0.
  - AI=0: every byte targets the same address.
- Handshake:
  - Transfer occurs in any cycle with reg_wr_valid_out & reg_wr_ready_in.
  - reg_wr_valid_out drops the next cycle unless a new byte is loaded in the same cycle (back-to-back).
  - reg_addr_out/reg_data_out must not change while valid is high and not accepted.
- Backpressure:
  - A byte arriving while valid=1 and ready=0 is dropped and sets overrun_out.
  - The address still advances when AI=1, preserving byte position.
- End of transaction: a pending write survives chip-select deassertion and completes normally; busy_out drops immediately.
- Sticky flags:
  - err_clear_in clears both flags.
  - Set has priority over a clear in the same cycle.
- Byte spacing: consecutive rx_valid_in pulses are at least 2 cycles apart. Closer spacing is outside the specified operating range; no detection is required.

Decomposition:
- Shared package tone_gen_pkg:
  - State enum (IDLE, ADDR, DATA, DROP).
  - Address-byte field constants: AI bit index = 7.
  - Default ADDR_W and NUM_REGS constants.
- Sub-module wr_hold_reg: one-entry valid/ready holding register.
  - Ports: load, addr, data, ready; outputs valid and overrun strobe.
  - Reusable for other register-file clients.
- Top level keeps the FSM, address counter and sticky flags.

Test Plan:
- Single write, ready tied 1: CS low, bytes 0x03, 0xA5, CS high -> one pulse of reg_wr_valid_out with addr=3, data=0xA5 one cycle after the second rx_valid_in; flags 0.
- Auto-increment wrap: bytes 0x8E, 0x11, 0x22, 0x33 -> three writes (0xE,0x11), (0xF,0x22), (0x0,0x33).
- No auto-increment: bytes 0x05, 0x10, 0x20 -> writes (5,0x10), (5,0x20).
- Illegal address, NUM_REGS=12: bytes 0x0C, 0x55 -> no write, addr_err_out=1. Next pulse of err_clear_in -> addr_err_out=0.
- Backpressure: ready=0, bytes 0x82, 0xAA, 0xBB -> valid held with (2,0xAA), overrun_out=1, 0xBB dropped. Ready raised -> write (2,0xAA) accepted, then valid=0. A following byte in the same transaction targets address 4.
- CS abort and async reset: CS deasserted after the address byte -> busy_out=0, next transaction parses a fresh address byte. reset_n_in low while valid=1 -> all outputs 0 immediately and no write after release.
